// File: rtl/lsu_pkg.sv
// lsu_pkg: shared width codes, FSM states and lane-mask helpers for the load/store unit
package lsu_pkg;
  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;
  localparam logic [3:0] MASK_B = 4'b0001;
  localparam logic [3:0] MASK_H = 4'b0011;
  localparam logic [3:0] MASK_W = 4'b1111;
  function automatic logic f3_bad(input logic [2:0] f3, input logic [1:0] off);
    return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) ||
           ((f3 == F3_H || f3 == F3_HU) && off[0]) ||
           (f3 == F3_W && off != 2'b00);
  endfunction
  // only valid for legal codes: bit 0 separates halfword from byte once W is excluded
  function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] off);
    return f3 == F3_W ? MASK_W : f3[0] ? MASK_H << {off[1], 1'b0} : MASK_B << off;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: picks the addressed byte/half of a loaded word and sign- or zero-extends it
module lsu_load_align
  import lsu_pkg::*;
#(
  parameter int REG_SIZE = 32
) (
  input  logic [REG_SIZE-1:0] word_i,
  input  logic [1:0]          offset_i,
  input  logic [2:0]          funct3_i,
  output logic [REG_SIZE-1:0] result_o
);
  logic [7:0]  b;
  logic [15:0] h;
  assign b = word_i[{offset_i, 3'b000} +: 8];
  assign h = word_i[{offset_i[1], 4'b0000} +: 16];
  always_comb
    result_o = funct3_i == F3_W  ? word_i :
               funct3_i == F3_H  ? REG_SIZE'($signed(h)) :
               funct3_i == F3_HU ? REG_SIZE'(h) :
               funct3_i == F3_B  ? REG_SIZE'($signed(b)) : REG_SIZE'(b);
endmodule

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: single-outstanding load/store controller between the pipeline and a combinational data_mem
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int REG_SIZE   = 32,
  parameter int NO_OF_REGS = 256
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                is_store_i,
  input  logic [2:0]          funct3_i,
  input  logic [REG_SIZE-1:0] addr_i,
  input  logic [REG_SIZE-1:0] wdata_i,
  output logic                dmem_cs_o,
  output logic                dmem_we_o,
  output logic [3:0]          dmem_mask_o,
  output logic [REG_SIZE-1:0] dmem_addr_o,
  output logic [REG_SIZE-1:0] dmem_wdata_o,
  input  logic [REG_SIZE-1:0] dmem_rdata_i,
  output logic                rsp_valid_o,
  output logic                rsp_err_o,
  output logic [REG_SIZE-1:0] rsp_rdata_o,
  input  logic                rsp_ready_i
);
  state_e              state_q, state_d;
  logic                is_store_q, is_store_d, err_q, err_d, req_err;
  logic [2:0]          funct3_q, funct3_d;
  logic [REG_SIZE-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, load_res;
  assign req_err = f3_bad(funct3_i, addr_i[1:0]) ||
                   ({2'b00, addr_i[REG_SIZE-1:2]} >= REG_SIZE'(NO_OF_REGS));
  assign dmem_addr_o  = {2'b00, addr_q[REG_SIZE-1:2]};
  assign dmem_wdata_o = funct3_q == F3_W ? wdata_q :
                        funct3_q[0] ? REG_SIZE'({2{wdata_q[15:0]}}) : REG_SIZE'({4{wdata_q[7:0]}});
  assign rsp_err_o    = err_q;
  assign rsp_rdata_o  = rdata_q;
  lsu_load_align #(.REG_SIZE(REG_SIZE)) u_align (
    .word_i   (dmem_rdata_i),
    .offset_i (addr_q[1:0]),
    .funct3_i (funct3_q),
    .result_o (load_res)
  );
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    funct3_d    = funct3_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    err_d       = err_q;
    rdata_d     = rdata_q;
    req_ready_o = 1'b0;
    dmem_cs_o   = 1'b0;
    dmem_we_o   = 1'b0;
    dmem_mask_o = 4'b0000;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          is_store_d = is_store_i;
          funct3_d   = funct3_i;
          addr_d     = addr_i;
          wdata_d    = wdata_i;
          err_d      = req_err;
          rdata_d    = '0;
          state_d    = req_err ? S_RESP : S_ACCESS;
        end
      end
      S_ACCESS: begin
        dmem_cs_o   = 1'b1;
        dmem_we_o   = is_store_q;
        dmem_mask_o = lane_mask(funct3_q, addr_q[1:0]);
        rdata_d     = is_store_q ? '0 : load_res;
        state_d     = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = rsp_ready_i ? S_IDLE : S_RESP;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      state_q    <= S_IDLE;
      is_store_q <= 1'b0;
      funct3_q   <= 3'b000;
      addr_q     <= '0;
      wdata_q    <= '0;
      err_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      is_store_q <= is_store_d;
      funct3_q   <= funct3_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      err_q      <= err_d;
      rdata_q    <= rdata_d;
    end
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: directed and random load/store traffic checked against a byte-level memory model
module tb_lsu_ctrl;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req_valid = 1'b0, req_ready, is_store = 1'b0, rsp_ready = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] addr = '0, wdata = '0, dmem_addr, dmem_wdata, dmem_rdata, rsp_rdata, last_rdata;
  logic        cs, we, rsp_valid, rsp_err;
  logic [3:0]  mask;
  logic [31:0] dmem [256];
  logic [31:0] ref_mem [256];
  int          n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  lsu_ctrl #(.REG_SIZE(32), .NO_OF_REGS(256)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .is_store_i(is_store), .funct3_i(funct3), .addr_i(addr), .wdata_i(wdata),
    .dmem_cs_o(cs), .dmem_we_o(we), .dmem_mask_o(mask), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_rdata_i(dmem_rdata), .rsp_valid_o(rsp_valid),
    .rsp_err_o(rsp_err), .rsp_rdata_o(rsp_rdata), .rsp_ready_i(rsp_ready)
  );
  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] nw, logic [3:0] m);
    logic [31:0] r = old;
    for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = nw[8*i +: 8];
    return r;
  endfunction
  assign dmem_rdata = dmem_addr < 256 ? dmem[dmem_addr[7:0]] : 32'h0;
  always @(posedge clk)
    if (cs && we && dmem_addr < 256) dmem[dmem_addr[7:0]] <= merge(dmem[dmem_addr[7:0]], dmem_wdata, mask);
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic m_err(logic [2:0] f, logic [31:0] a);
    return f == 3 || f == 6 || f == 7 || ((f == 1 || f == 5) && a[0]) ||
           (f == 2 && a[1:0] != 0) || (a >> 2) >= 256;
  endfunction
  function automatic logic [3:0] m_mask(logic [2:0] f, logic [31:0] a);
    if (f == 2) return 4'hF;
    if (f == 1 || f == 5) return a[1] ? 4'hC : 4'h3;
    return 4'h1 << a[1:0];
  endfunction
  function automatic logic [31:0] m_wdata(logic [2:0] f, logic [31:0] wd);
    if (f == 2) return wd;
    if (f == 1 || f == 5) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction
  function automatic logic [31:0] m_load(logic [2:0] f, logic [31:0] a);
    logic [31:0] w = ref_mem[a[9:2]], v;
    if (f == 2) return w;
    if (f == 1 || f == 5) begin
      v = (w >> (16 * a[1])) & 32'hFFFF;
      if (f == 1 && v >= 32'h8000) v = v - 32'h1_0000;
    end else begin
      v = (w >> (8 * a[1:0])) & 32'hFF;
      if (f == 0 && v >= 32'h80) v = v - 32'h100;
    end
    return v;
  endfunction
  task automatic m_store(input logic [2:0] f, input logic [31:0] a, input logic [31:0] wd);
    logic [3:0] m = m_mask(f, a);
    for (int i = 0; i < 4; i++)
      if (m[i]) begin
        logic [31:0] lane = f == 2 ? wd >> (8 * i) : (f == 1 || f == 5) ? wd >> (8 * (i % 2)) : wd;
        ref_mem[a[9:2]][8*i +: 8] = lane[7:0];
      end
  endtask
  task automatic poke(input int idx, input logic [31:0] v);
    dmem[idx] = v;
    ref_mem[idx] = v;
  endtask
  task automatic do_req(input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input int hold, input logic overlap);
    logic        err = m_err(f, a);
    logic [31:0] er = 32'h0;
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'h1);
    req_valid = 1'b1; is_store = st; funct3 = f; addr = a; wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; addr = $urandom; wdata = $urandom; funct3 = 3'($urandom);
    if (err) begin
      check("err_no_cs", 32'(cs), 32'h0);
    end else begin
      check("acc_cs", 32'(cs), 32'h1);
      check("acc_we", 32'(we), 32'(st));
      check("acc_mask", 32'(mask), 32'(m_mask(f, a)));
      check("acc_addr", dmem_addr, a >> 2);
      if (st) check("acc_wdata", dmem_wdata, m_wdata(f, wd));
      check("acc_no_rsp", 32'(rsp_valid), 32'h0);
      if (st) m_store(f, a, wd);
      else er = m_load(f, a);
      @(posedge clk); #1;
      check("rsp_cs_low", 32'(cs), 32'h0);
    end
    check("rsp_valid", 32'(rsp_valid), 32'h1);
    check("rsp_err", 32'(rsp_err), 32'(err));
    check("rsp_rdata", rsp_rdata, er);
    last_rdata = rsp_rdata;
    repeat (hold) begin
      @(posedge clk); #1;
      check("hold_valid", 32'(rsp_valid), 32'h1);
      check("hold_err", 32'(rsp_err), 32'(err));
      check("hold_rdata", rsp_rdata, er);
      check("hold_ready", 32'(req_ready), 32'h0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    if (overlap) begin
      req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h0; wdata = 32'hDEAD_BEEF;
    end
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check("exit_valid", 32'(rsp_valid), 32'h0);
    check("exit_ready", 32'(req_ready), 32'h1);
    check("exit_cs", 32'(cs), 32'h0);
  endtask
  initial begin
    for (int i = 0; i < 256; i++) poke(i, $urandom);
    #1 check("rst_cs", 32'(cs), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_valid", 32'(rsp_valid), 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    poke(1, 32'h80FF_0000);
    do_req(1'b0, 3'd0, 32'h7, 32'h0, 0, 1'b0);
    check("spec_lb", last_rdata, 32'hFFFF_FF80);
    do_req(1'b0, 3'd4, 32'h7, 32'h0, 0, 1'b0);
    check("spec_lbu", last_rdata, 32'h0000_0080);
    poke(0, 32'h8001_1234);
    do_req(1'b0, 3'd1, 32'h2, 32'h0, 0, 1'b0);
    check("spec_lh", last_rdata, 32'hFFFF_8001);
    do_req(1'b0, 3'd2, 32'h1, 32'h0, 1, 1'b0);
    do_req(1'b1, 3'd0, 32'h6, 32'hAB, 0, 1'b1);
    check("spec_sb_mem", dmem[1], 32'h80AB_0000);
    do_req(1'b1, 3'd2, 32'h8, 32'hCAFE_F00D, 3, 1'b0);
    check("spec_sw_mem", dmem[2], 32'hCAFE_F00D);
    do_req(1'b0, 3'd3, 32'h4, 32'h0, 0, 1'b0);
    do_req(1'b0, 3'd2, 32'h400, 32'h0, 0, 1'b0);
    do_req(1'b1, 3'd2, 32'h400, 32'h1234_5678, 0, 1'b0);
    @(negedge clk);
    req_valid = 1'b1; is_store = 1'b1; funct3 = 3'd2; addr = 32'h8; wdata = 32'h5555_AAAA;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("abort_cs_before", 32'(cs), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("abort_cs", 32'(cs), 32'h0);
    check("abort_we", 32'(we), 32'h0);
    check("abort_mask", 32'(mask), 32'h0);
    check("abort_valid", 32'(rsp_valid), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready), 32'h1);
    check("abort_mem", dmem[2], ref_mem[2]);
    for (int t = 0; t < 300; t++) begin
      logic [2:0]  f = 3'($urandom_range(0, 7));
      logic [31:0] a = $urandom_range(0, 1023);
      if ($urandom_range(0, 3) == 0) a = a & ~32'h3;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      do_req(1'($urandom_range(0, 1)), f, a, $urandom, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    for (int i = 0; i < 256; i++) check($sformatf("mem_%0d", i), dmem[i], ref_mem[i]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
